// File: rtl/branch_pkg.sv
// Shared encodings and helpers for branch resolution and prediction.
package branch_pkg;

  // branch_cntrl condition-select encodings
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BGEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLEZ = 3'b101,
    BR_BLTZ = 3'b110,
    BR_JUMP = 3'b111
  } br_cntrl_e;

  // 2-bit saturating counter states; bit[1] is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Step a counter toward taken/not-taken, saturating at both ends.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational MIPS conditional-branch evaluator.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            branch_cntrl,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic                  zero,
  output logic                  cond
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[DATA_WIDTH-1];
  assign rs_zero = (rs == '0);

  // Select the branch condition from the control code.
  always_comb begin
    cond = 1'b0;
    case (branch_cntrl)
      BR_NONE: cond = 1'b0;
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_BGEZ: cond = ~rs_neg;
      BR_BGTZ: cond = ~rs_neg & ~rs_zero;
      BR_BLEZ: cond = rs_neg | rs_zero;
      BR_BLTZ: cond = rs_neg;
      BR_JUMP: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch resolution with a 2-bit BHT predictor and mispredict statistics.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  pred_valid,
  input  logic [DATA_WIDTH-1:0] pred_pc,
  output logic                  pred_taken,
  input  logic                  resolve_valid,
  input  logic [DATA_WIDTH-1:0] resolve_pc,
  input  logic [2:0]            branch_cntrl,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic                  zero,
  input  logic                  pred_taken_in,
  output logic                  branch_out,
  output logic                  mispredict,
  output logic                  flush,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]           bht_q [BHT_DEPTH];
  logic [IDX_W-1:0]     pred_idx;
  logic [IDX_W-1:0]     res_idx;
  logic                 cond;
  logic                 qual;
  logic                 branch_out_q, branch_out_d;
  logic                 mispredict_q, mispredict_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           bht_upd_d;
  logic                 unused_pc_bits;

  // Word-aligned PC bits select the BHT entry; the rest do not participate.
  assign pred_idx       = pred_pc[IDX_W+1:2];
  assign res_idx        = resolve_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[DATA_WIDTH-1:IDX_W+2], pred_pc[1:0],
                            resolve_pc[DATA_WIDTH-1:IDX_W+2], resolve_pc[1:0]};

  branch_cond_eval #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cond (
    .branch_cntrl(branch_cntrl),
    .rs          (rs),
    .zero        (zero),
    .cond        (cond)
  );

  // Fetch-time prediction reads the current (pre-update) counter.
  assign pred_taken = pred_valid & bht_q[pred_idx][1];

  // Ops arriving while a flush is in flight are wrong-path and ignored.
  assign qual = resolve_valid & (branch_cntrl != 3'(BR_NONE)) & ~mispredict_q;

  // Next-state for outcome, mispredict pulse, statistics and BHT entry.
  always_comb begin
    branch_out_d = 1'b0;
    mispredict_d = 1'b0;
    cnt_d        = cnt_q;
    bht_upd_d    = ctr_update(bht_q[res_idx], cond);
    if (qual) begin
      branch_out_d = cond;
      mispredict_d = (cond != pred_taken_in);
      if (mispredict_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Result/statistics registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      branch_out_q <= 1'b0;
      mispredict_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      branch_out_q <= branch_out_d;
      mispredict_q <= mispredict_d;
      cnt_q        <= cnt_d;
    end
  end

  // BHT: reset to weakly not-taken, train the resolving entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= WNT;
    end else if (qual) begin
      bht_q[res_idx] <= bht_upd_d;
    end
  end

  assign branch_out       = branch_out_q;
  assign mispredict       = mispredict_q;
  assign flush            = mispredict_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed self-checking bench for branch_predict_resolve.
module tb_branch_predict_resolve;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          pred_valid = 1'b0;
  logic [DW-1:0] pred_pc = '0;
  logic          pred_taken;
  logic          resolve_valid = 1'b0;
  logic [DW-1:0] resolve_pc = '0;
  logic [2:0]    branch_cntrl = 3'd0;
  logic [DW-1:0] rs = '0;
  logic          zero = 1'b0;
  logic          pred_taken_in = 1'b0;
  logic          branch_out;
  logic          mispredict;
  logic          flush;
  logic [CW-1:0] mispredict_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  branch_predict_resolve #(
    .DATA_WIDTH(DW),
    .BHT_DEPTH (64),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .pred_valid      (pred_valid),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .resolve_valid   (resolve_valid),
    .resolve_pc      (resolve_pc),
    .branch_cntrl    (branch_cntrl),
    .rs              (rs),
    .zero            (zero),
    .pred_taken_in   (pred_taken_in),
    .branch_out      (branch_out),
    .mispredict      (mispredict),
    .flush           (flush),
    .mispredict_count(mispredict_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected condition written from signed comparisons.
  function automatic logic exp_cond(input logic [2:0] c, input logic [31:0] r, input logic z);
    case (c)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return $signed(r) >= 0;
      3'd4:    return $signed(r) > 0;
      3'd5:    return $signed(r) <= 0;
      3'd6:    return $signed(r) < 0;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] c, input logic [31:0] r,
                         input logic z, input logic pin);
    resolve_valid = 1'b1;
    resolve_pc    = pc;
    branch_cntrl  = c;
    rs            = r;
    zero          = z;
    pred_taken_in = pin;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    branch_cntrl  = 3'd0;
    pred_taken_in = 1'b0;
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
    pred_valid = 1'b1;
    pred_pc    = pc;
    #1;
    chk(tag, 32'(pred_taken), 32'(exp));
    pred_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rsv [4];
    logic        c;
    rsv[0] = 32'h0000_0001;
    rsv[1] = 32'hFFFF_FFFF;
    rsv[2] = 32'h0000_0000;
    rsv[3] = 32'hF000_0000;

    // reset state
    #3;
    chk("rst_branch_out", 32'(branch_out), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_count", 32'(mispredict_count), 32'd0);
    peek("rst_pred", 32'h0040_0010, 1'b0);
    Reset = 1'b0;
    step();

    // condition sweep, idle cycle after each resolve to clear any flush
    for (int r = 0; r < 4; r++) begin
      for (int z = 0; z < 2; z++) begin
        for (int k = 0; k < 8; k++) begin
          c = exp_cond(3'(k), rsv[r], z[0]);
          resolve(32'h0000_1000, 3'(k), rsv[r], z[0], 1'b0);
          step();
          chk($sformatf("sweep_bo rs=%h z=%0d c=%0d", rsv[r], z, k), 32'(branch_out), 32'(c));
          chk($sformatf("sweep_mp rs=%h z=%0d c=%0d", rsv[r], z, k), 32'(mispredict), 32'(c));
          if (c) bump_cnt();
          idle();
          step();
        end
      end
    end
    chk("sweep_count", 32'(mispredict_count), 32'(exp_cnt));
    chk("sweep_bo_idle", 32'(branch_out), 32'd0);

    // reset clears everything, including the trained sweep entry
    Reset = 1'b1;
    #2;
    chk("rst2_count", 32'(mispredict_count), 32'd0);
    peek("rst2_pred_idx0", 32'h0000_1000, 1'b0);
    Reset = 1'b0;
    exp_cnt = 0;
    step();

    // training at 0x00400010
    resolve(32'h0040_0010, 3'd1, 32'd0, 1'b1, 1'b0);
    step();
    chk("train1_mp", 32'(mispredict), 32'd1);
    chk("train1_flush", 32'(flush), 32'd1);
    chk("train1_bo", 32'(branch_out), 32'd1);
    chk("train1_cnt", 32'(mispredict_count), 32'd1);
    idle();
    peek("train1_pred", 32'h0040_0010, 1'b1);
    step();
    chk("train1_mp_drop", 32'(mispredict), 32'd0);
    resolve(32'h0040_0010, 3'd1, 32'd0, 1'b1, 1'b1);
    step();
    chk("train2_mp", 32'(mispredict), 32'd0);
    resolve(32'h0040_0010, 3'd1, 32'd0, 1'b1, 1'b1);
    step();
    chk("train3_mp", 32'(mispredict), 32'd0);
    chk("train3_bo", 32'(branch_out), 32'd1);
    chk("train3_cnt", 32'(mispredict_count), 32'd1);
    // 11 -> 10 stays taken only if the counter saturated rather than wrapped
    resolve(32'h0040_0010, 3'd1, 32'd0, 1'b0, 1'b1);
    step();
    chk("train4_mp", 32'(mispredict), 32'd1);
    chk("train4_cnt", 32'(mispredict_count), 32'd2);
    idle();
    peek("train4_pred_sat", 32'h0040_0010, 1'b1);
    step();
    resolve(32'h0040_0010, 3'd1, 32'd0, 1'b0, 1'b0);
    step();
    chk("train5_mp", 32'(mispredict), 32'd0);
    idle();
    peek("train5_pred", 32'h0040_0010, 1'b0);

    // wrong-path suppression at 0x00400030
    resolve(32'h0040_0030, 3'd1, 32'd0, 1'b1, 1'b0);
    step();
    chk("wp_n_mp", 32'(mispredict), 32'd1);
    chk("wp_n_cnt", 32'(mispredict_count), 32'd3);
    resolve(32'h0040_0030, 3'd2, 32'd0, 1'b0, 1'b0);
    step();
    chk("wp_n2_bo", 32'(branch_out), 32'd0);
    chk("wp_n2_mp", 32'(mispredict), 32'd0);
    chk("wp_n2_cnt", 32'(mispredict_count), 32'd3);
    resolve(32'h0040_0030, 3'd1, 32'd0, 1'b0, 1'b0);
    step();
    idle();
    peek("wp_bht_unchanged", 32'h0040_0030, 1'b0);

    // same-index read-before-write at 0x00400020
    pred_valid = 1'b1;
    pred_pc    = 32'h0040_0020;
    resolve(32'h0040_0020, 3'd7, 32'd0, 1'b0, 1'b0);
    #1;
    chk("rw_same_cycle", 32'(pred_taken), 32'd0);
    step();
    chk("rw_next_cycle", 32'(pred_taken), 32'd1);
    chk("rw_cnt", 32'(mispredict_count), 32'd4);
    pred_valid = 1'b0;
    #1;
    chk("rw_pred_valid0", 32'(pred_taken), 32'd0);
    idle();
    step();

    // back-to-back non-mispredicting resolves at adjacent entries
    resolve(32'h0000_0050, 3'd7, 32'd0, 1'b0, 1'b1);
    step();
    chk("b2b_a_bo", 32'(branch_out), 32'd1);
    resolve(32'h0000_0054, 3'd7, 32'd0, 1'b0, 1'b1);
    step();
    chk("b2b_b_bo", 32'(branch_out), 32'd1);
    chk("b2b_b_mp", 32'(mispredict), 32'd0);
    idle();
    peek("b2b_pred_a", 32'h0000_0050, 1'b1);
    peek("b2b_pred_b", 32'h0000_0054, 1'b1);
    step();
    chk("b2b_bo_idle", 32'(branch_out), 32'd0);

    // counter saturation: 20 separated mispredicts from a count of 4
    exp_cnt = 4;
    for (int i = 0; i < 20; i++) begin
      resolve(32'h0000_0100, 3'd7, 32'd0, 1'b0, 1'b0);
      step();
      bump_cnt();
      chk($sformatf("sat_cnt_%0d", i), 32'(mispredict_count), 32'(exp_cnt));
      idle();
      step();
    end
    chk("sat_final", 32'(mispredict_count), 32'hF);

    // asynchronous reset between edges while mispredict is high
    resolve(32'h0000_0200, 3'd7, 32'd0, 1'b0, 1'b0);
    step();
    idle();
    chk("arst_pre_mp", 32'(mispredict), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_mp", 32'(mispredict), 32'd0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_bo", 32'(branch_out), 32'd0);
    chk("arst_cnt", 32'(mispredict_count), 32'd0);
    Reset = 1'b0;
    step();
    peek("arst_pred_50", 32'h0000_0050, 1'b0);
    peek("arst_pred_100", 32'h0000_0100, 1'b0);
    peek("arst_pred_200", 32'h0000_0200, 1'b0);
    peek("arst_pred_20", 32'h0040_0020, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
